// File: rtl/shift_load_arbiter.sv
// -----------------------------------------------------------------------------
// shift_load_arbiter
//
// Two-requester round-robin front end for a WIDTH-stage serial shift register.
// A granted word is captured, driven LSB-first on SDOUT for WIDTH cycles, and
// VALID pulses once the external register holds the whole word.
//
// Ports
//   CLK        in   rising-edge clock, shared with the shift register
//   RST        in   synchronous active-high reset, shared with the register
//   REQ0/REQ1  in   request lines, held high until the matching ACK is seen
//   DATA0/1    in   WIDTH-bit words, stable while the matching REQ is high
//   ACK0/ACK1  out  one-cycle grant; the word is captured at the end of it
//   SDOUT      out  serial bit toward the shift register Din
//   BUSY       out  high from the grant cycle through the VALID cycle
//   VALID      out  one-cycle strobe: register holds the granted word
//   OWNER      out  requester index of the current / most recent transfer
//   DBG_STATE  out  FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a requester raises REQx with DATAx stable and keeps both until
// it sees ACKx=1 in some cycle. ACKx is combinational from REQx in IDLE, so
// the word is taken at the clock edge that closes the ACK cycle. Dropping REQx
// before an ACK withdraws the request with no effect. WIDTH must be >= 2.
// -----------------------------------------------------------------------------
module shift_load_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DATA0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA1,
  output logic             ACK1,
  output logic             SDOUT,
  output logic             BUSY,
  output logic             VALID,
  output logic             OWNER,
  output logic [1:0]       DBG_STATE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_owner;
  logic             r_last;

  logic             w_grant0;
  logic             w_grant1;

  // Grants only happen in IDLE. On a tie the requester that was not served
  // last wins; r_last resets to 1 so requester 0 wins the first tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (REQ0 && REQ1) begin
        if (r_last) w_grant0 = 1'b1;
        else        w_grant1 = 1'b1;
      end else begin
        w_grant0 = REQ0;
        w_grant1 = REQ1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_word  <= w_grant1 ? DATA1 : DATA0;
            r_owner <= w_grant1;
            r_last  <= w_grant1;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Pending requests are arbitrated in the following IDLE cycle.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ACK0      = w_grant0;
  assign ACK1      = w_grant1;
  // Zero outside SHIFT so the register flushes toward zero between words.
  assign SDOUT     = (r_state == ST_SHIFT) ? r_word[r_cnt] : 1'b0;
  assign BUSY      = w_grant0 || w_grant1 || (r_state != ST_IDLE);
  assign VALID     = (r_state == ST_DONE);
  assign OWNER     = r_owner;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_shift_load_arbiter.sv
module tb_shift_load_arbiter;

  localparam int W  = 4;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (WIDTH=4) ----------------
  logic          req0, req1, ack0, ack1, sdout, busy, valid, owner;
  logic [W-1:0]  data0, data1;
  logic [1:0]    dbg;

  shift_load_arbiter #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .DATA0(data0), .ACK0(ack0),
    .REQ1(req1), .DATA1(data1), .ACK1(ack1),
    .SDOUT(sdout), .BUSY(busy), .VALID(valid), .OWNER(owner),
    .DBG_STATE(dbg)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic          req0_8, req1_8, ack0_8, ack1_8, sdout_8, busy_8, valid_8, owner_8;
  logic [W8-1:0] data0_8, data1_8;
  logic [1:0]    dbg_8;

  shift_load_arbiter #(.WIDTH(W8)) dut8 (
    .CLK(clk), .RST(rst),
    .REQ0(req0_8), .DATA0(data0_8), .ACK0(ack0_8),
    .REQ1(req1_8), .DATA1(data1_8), .ACK1(ack1_8),
    .SDOUT(sdout_8), .BUSY(busy_8), .VALID(valid_8), .OWNER(owner_8),
    .DBG_STATE(dbg_8)
  );

  // ---------------- external shift registers (Din enters top, LSB lands in Q0) ----------------
  logic [W-1:0]  sr4;
  logic [W8-1:0] sr8;
  always @(posedge clk) begin
    if (rst) begin
      sr4 <= '0;
      sr8 <= '0;
    end else begin
      sr4 <= {sdout, sr4[W-1:1]};
      sr8 <= {sdout_8, sr8[W8-1:1]};
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard: {owner, word} pushed at grant, popped at VALID ----------------
  logic [W:0] exp_q[$];
  int         g_q[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      g_q.delete();
    end else begin
      if (ack0 || ack1) begin
        n_checks++; if ((ack0 && ack1) !== 1'b0) $display("FAIL ack_overlap: ack0=%b ack1=%b expected not both", ack0, ack1); else n_pass++;
        if (ack1) exp_q.push_back({1'b1, data1});
        else      exp_q.push_back({1'b0, data0});
        g_q.push_back(cyc);
      end
      if (valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_valid: got VALID at cycle %0d expected none", cyc);
        end else begin
          logic [W:0] e;
          int g;
          e = exp_q.pop_front();
          g = g_q.pop_front();
          if ({owner, sr4} !== e) $display("FAIL sb_word: got owner/reg %h expected %h", {owner, sr4}, e);
          else n_pass++;
          n_checks++; if (cyc - g !== W + 1) $display("FAIL sb_latency: got %0d expected %0d", cyc - g, W + 1); else n_pass++;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req0_8 = 1'b0; req1_8 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ack0, ack1, sdout, busy, valid, owner} !== 6'b0) $display("FAIL reset_outputs: got %b expected 000000", {ack0, ack1, sdout, busy, valid, owner}); else n_pass++;
    n_checks++; if (dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg); else n_pass++;
    n_checks++; if (sr4 !== 4'h0) $display("FAIL reset_reg: got %h expected 0", sr4); else n_pass++;
    n_checks++; if ({ack0_8, ack1_8, sdout_8, busy_8, valid_8, owner_8} !== 6'b0) $display("FAIL reset_outputs8: got %b expected 000000", {ack0_8, ack1_8, sdout_8, busy_8, valid_8, owner_8}); else n_pass++;
  endtask

  task automatic test_single();
    logic [W-1:0] pat;
    bit got;
    pat = 4'b1011;
    tick();
    req0 = 1'b1; data0 = pat;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL single_ack: got no ACK0 expected ACK0"); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_grant: got %b expected 1", busy); else n_pass++;
    tick();
    req0 = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
      n_checks++; if (sdout !== pat[k]) $display("FAIL single_sdout bit%0d: got %b expected %b", k, sdout, pat[k]); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_shift: got %b expected 1", busy); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", valid); else n_pass++;
    n_checks++; if (owner !== 1'b0) $display("FAIL single_owner: got %b expected 0", owner); else n_pass++;
    n_checks++; if (sr4 !== pat) $display("FAIL single_reg: got %h expected %h", sr4, pat); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_done: got %b expected 1", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy, valid} !== 2'b00) $display("FAIL single_after: got busy/valid %b expected 00", {busy, valid}); else n_pass++;
  endtask

  task automatic test_tie();
    bit got;
    int g0;
    do_reset();
    req0 = 1'b1; data0 = 4'h5;
    req1 = 1'b1; data1 = 4'hA;
    got = 1'b0;
    g0 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1'b1;
        g0 = cyc;
        n_checks++; if ({ack0, ack1} !== 2'b10) $display("FAIL tie_first: got ack0/ack1 %b expected 10", {ack0, ack1}); else n_pass++;
      end
    end
    tick();
    req0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack1) begin
        got = 1'b1;
        n_checks++; if (cyc - g0 !== W + 2) $display("FAIL tie_second_gap: got %0d expected %0d", cyc - g0, W + 2); else n_pass++;
      end
    end
    n_checks++; if (got !== 1'b1) $display("FAIL tie_ack1: got no ACK1 expected ACK1"); else n_pass++;
    tick();
    req1 = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    int   vcyc[4];
    logic vown[4];
    logic [3:0] exp_own;
    int   n;
    exp_own = 4'b1010;  // index i -> owner: 0,1,0,1
    do_reset();
    req0 = 1'b1; data0 = 4'h3;
    req1 = 1'b1; data1 = 4'hC;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (valid) begin
        vcyc[n] = cyc;
        vown[n] = owner;
        n++;
      end
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    n_checks++; if (n !== 4) $display("FAIL b2b_count: got %0d expected 4", n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        n_checks++; if (vown[i] !== exp_own[i]) $display("FAIL b2b_owner%0d: got %b expected %b", i, vown[i], exp_own[i]); else n_pass++;
        if (i > 0) begin
          n_checks++; if (vcyc[i] - vcyc[i-1] !== W + 2) $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, vcyc[i] - vcyc[i-1], W + 2); else n_pass++;
        end
      end
    end
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    int nv;
    do_reset();
    req1 = 1'b1; data1 = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack1) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL rstmid_ack1: got no ACK1 expected ACK1"); else n_pass++;
    tick();             // first SHIFT cycle
    req1 = 1'b0;
    tick();             // second SHIFT cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ack0, ack1, sdout, busy, valid, owner} !== 6'b0) $display("FAIL rstmid_outputs: got %b expected 000000", {ack0, ack1, sdout, busy, valid, owner}); else n_pass++;
    n_checks++; if (sr4 !== 4'h0) $display("FAIL rstmid_reg: got %h expected 0", sr4); else n_pass++;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    n_checks++; if (nv !== 0) $display("FAIL rstmid_no_valid: got %0d VALIDs expected 0", nv); else n_pass++;
    tick();
    req0 = 1'b1; data0 = 4'h6;
    req1 = 1'b1; data1 = 4'h9;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1'b1;
        n_checks++; if ({ack0, ack1} !== 2'b10) $display("FAIL rstmid_tie: got ack0/ack1 %b expected 10", {ack0, ack1}); else n_pass++;
      end
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_withdraw();
    bit got;
    int na1;
    tick();
    req0 = 1'b1; data0 = 4'h3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b1; data1 = 4'h5;
    tick();
    req1 = 1'b0;
    na1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack1) na1++;
    end
    n_checks++; if (na1 !== 0) $display("FAIL withdraw_ack1: got %0d ACK1 expected 0", na1); else n_pass++;
    n_checks++; if ({busy, dbg} !== 3'b000) $display("FAIL withdraw_idle: got busy/state %b expected 000", {busy, dbg}); else n_pass++;
  endtask

  task automatic test_width8();
    logic [W8-1:0] pat;
    bit got;
    int g;
    pat = 8'hC3;
    tick();
    req0_8 = 1'b1; data0_8 = pat;
    got = 1'b0;
    g = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0_8) begin
        got = 1'b1;
        g = cyc;
      end
    end
    n_checks++; if (got !== 1'b1) $display("FAIL w8_ack: got no ACK0 expected ACK0"); else n_pass++;
    tick();
    req0_8 = 1'b0;
    for (int k = 0; k < W8; k++) begin
      @(negedge clk);
      n_checks++; if (sdout_8 !== pat[k]) $display("FAIL w8_sdout bit%0d: got %b expected %b", k, sdout_8, pat[k]); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (valid_8 !== 1'b1) $display("FAIL w8_valid: got %b expected 1", valid_8); else n_pass++;
    n_checks++; if (cyc - g !== W8 + 1) $display("FAIL w8_latency: got %0d expected %0d", cyc - g, W8 + 1); else n_pass++;
    n_checks++; if (sr8 !== pat) $display("FAIL w8_reg: got %h expected %h", sr8, pat); else n_pass++;
    n_checks++; if (owner_8 !== 1'b0) $display("FAIL w8_owner: got %b expected 0", owner_8); else n_pass++;
    repeat (3) tick();
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    req0_8 = 1'b0; req1_8 = 1'b0; data0_8 = '0; data1_8 = '0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_withdraw();
    test_width8();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending words expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
